instr_encoder: RTL

- **Function:** encodes RISC-V instruction fields (class, registers, funct3, immediate) into 32-bit RV32I instruction words. Words are written sequentially into instruction memory.
- **Covered encodings:** exactly the instruction classes the control unit decodes, so this is the inverse of the decode path.
- **Use:** program loader ahead of the core, and self-check source for decoder benches.
- **Structure:** valid/ready field input feeding a FIFO of encoded words, drained into instruction memory through a write port with backpressure.

---
 rtl/instr_encoder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: turns field bundles (class, registers, funct3,
// immediate) into 32-bit instruction words and streams them into
// instruction memory through a small FIFO with a backpressured write port.
module instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int BASE   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_class,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  input  logic [2:0]                 in_funct3,
  input  logic                       in_f7b5,
  input  logic [12:0]                in_imm,
  output logic                       wr_en,
  input  logic                       wr_ready,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [31:0]                wr_data,
  output logic                       err,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       wrapped
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] CLS_R_ALU  = 3'd0;
  localparam logic [2:0] CLS_I_ALU  = 3'd1;
  localparam logic [2:0] CLS_LOAD   = 3'd2;
  localparam logic [2:0] CLS_STORE  = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;

  localparam logic [6:0] OP_R_ALU  = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [31:0]       mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] addr_q;
  logic              wrapped_q;
  logic              err_q;

  logic [31:0] word_d;
  logic        illegal_d;
  logic        imm12_bad;
  logic        accept, push, pop;

  // Encode the incoming bundle and flag bundles that cannot be represented.
  always_comb begin
    word_d    = '0;
    illegal_d = 1'b0;
    imm12_bad = (in_imm[12] != in_imm[11]);
    case (in_class)
      CLS_R_ALU:  word_d = {1'b0, in_f7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OP_R_ALU};
      CLS_I_ALU: begin
        word_d    = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I_ALU};
        illegal_d = imm12_bad;
      end
      CLS_LOAD: begin
        word_d    = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
        illegal_d = imm12_bad;
      end
      CLS_STORE: begin
        word_d    = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
        illegal_d = imm12_bad;
      end
      CLS_BRANCH: begin
        word_d    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], OP_BRANCH};
        illegal_d = in_imm[0];
      end
      default:    illegal_d = 1'b1;
    endcase
  end

  // Handshake: full blocks input even if a pop is happening this cycle.
  assign in_ready = !rst && (count_q < CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign push     = accept && !illegal_d;
  assign wr_en    = (count_q != '0);
  assign pop      = wr_en && wr_ready;

  // Occupancy follows push/pop; simultaneous push and pop cancel.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers, occupancy, address counter, wrap flag and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      addr_q    <= ADDR_W'(BASE);
      wrapped_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= accept && illegal_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        addr_q   <= addr_q + ADDR_W'(1);
        if (&addr_q) wrapped_q <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are don't-care while unoccupied so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word_d;
  end

  // Empty FIFO presents zero rather than a stale entry.
  assign wr_data = wr_en ? mem_q[rd_ptr_q] : 32'h0;
  assign wr_addr = addr_q;
  assign err     = err_q;
  assign count   = count_q;
  assign wrapped = wrapped_q;

endmodule
